// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NMASTERS masters, with
// bus lock while the owner holds cyc and a stall timeout that forces an error.
module wb_rr_arbiter #(
   parameter int NMASTERS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                                 wb_clk_i,
   input  logic                                 wb_rst_ni,
   input  logic [NMASTERS*ADDR_WIDTH-1:0]       wbm_adr_i,
   input  logic [NMASTERS*DATA_WIDTH-1:0]       wbm_dat_i,
   input  logic [NMASTERS*(DATA_WIDTH/8)-1:0]   wbm_sel_i,
   input  logic [NMASTERS-1:0]                  wbm_we_i,
   input  logic [NMASTERS-1:0]                  wbm_stb_i,
   input  logic [NMASTERS-1:0]                  wbm_cyc_i,
   output logic [DATA_WIDTH-1:0]                wbm_dat_o,
   output logic [NMASTERS-1:0]                  wbm_ack_o,
   output logic [NMASTERS-1:0]                  wbm_err_o,
   output logic [ADDR_WIDTH-1:0]                wbs_adr_o,
   output logic [DATA_WIDTH-1:0]                wbs_dat_o,
   output logic [DATA_WIDTH/8-1:0]              wbs_sel_o,
   output logic                                 wbs_we_o,
   output logic                                 wbs_stb_o,
   output logic                                 wbs_cyc_o,
   input  logic [DATA_WIDTH-1:0]                wbs_dat_i,
   input  logic                                 wbs_ack_i,
   input  logic                                 wbs_err_i,
   output logic [NMASTERS-1:0]                  grant_o,
   output logic                                 timeout_o
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t              state;
   logic [NMASTERS-1:0] grant;
   logic [PW-1:0]       gidx;
   logic [PW-1:0]       ptr;
   logic [CW-1:0]       cnt;

   logic [PW-1:0]       pick;
   logic [PW-1:0]       cand;
   logic                found;
   logic                m_cyc;
   logic                m_stb;
   logic                act_cyc;
   logic                stall;
   logic                hit;

   // First requester at or after ptr, wrapping modulo NMASTERS.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < NMASTERS; i++) begin
         cand = PW'((int'(ptr) + i) % NMASTERS);
         if (!found && wbm_cyc_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign m_cyc   = wbm_cyc_i[gidx];
   assign m_stb   = wbm_stb_i[gidx];
   assign act_cyc = (state == OWNED) && m_cyc;
   assign stall   = act_cyc && m_stb && !wbs_ack_i && !wbs_err_i;
   // A slave response in the final stall cycle takes precedence over the timeout.
   assign hit     = (TIMEOUT != 0) && stall && (cnt == CW'(TIMEOUT - 1));

   assign wbs_cyc_o = act_cyc && !hit;
   assign wbs_stb_o = act_cyc && m_stb && !hit;
   assign wbs_we_o  = wbm_we_i[gidx];
   assign wbs_adr_o = wbm_adr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign wbs_dat_o = wbm_dat_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
   assign wbs_sel_o = wbm_sel_i[int'(gidx)*SW +: SW];

   assign wbm_dat_o = wbs_dat_i;
   assign wbm_ack_o = {NMASTERS{act_cyc && wbs_ack_i}} & grant;
   assign wbm_err_o = {NMASTERS{act_cyc && (wbs_err_i || hit)}} & grant;
   assign grant_o   = grant;
   assign timeout_o = hit;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
         grant <= '0;
         gidx  <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (found) begin
                  state <= OWNED;
                  grant <= NMASTERS'(1) << pick;
                  gidx  <= pick;
                  ptr   <= (pick == PW'(NMASTERS - 1)) ? '0 : pick + PW'(1);
               end
            end
            OWNED: begin
               // Releasing always passes through IDLE, giving one dead cycle between owners.
               if (!m_cyc) begin
                  state <= IDLE;
                  grant <= '0;
                  cnt   <= '0;
               end else if (stall && !hit && (TIMEOUT != 0)) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
